// File: rtl/vedic_multiplier_2x2_pkg.sv
// vedic_multiplier_2x2_pkg: width constants shared by the Vedic multiplier family
package vedic_multiplier_2x2_pkg;
  localparam int VM2_IN_W  = 2;
  localparam int VM2_OUT_W = 4;
endpackage

// File: rtl/vedic_multiplier_2x2_half_adder.sv
// vedic_multiplier_2x2_half_adder: one-bit half adder cell
module vedic_multiplier_2x2_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/vedic_multiplier_2x2.sv
// vedic_multiplier_2x2: registered 2x2 Urdhva-Tiryagbhyam multiplier, LATENCY 1 or 2
module vedic_multiplier_2x2
  import vedic_multiplier_2x2_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [VM2_IN_W-1:0]  A,
  input  logic [VM2_IN_W-1:0]  B,
  output logic                 out_valid,
  output logic [VM2_OUT_W-1:0] P
);
  logic [VM2_IN_W-1:0]  core_a, core_b;
  logic                 core_v;
  logic                 c1, p1, p2, p3;
  logic [VM2_OUT_W-1:0] prod;
  logic [VM2_OUT_W-1:0] p_d, p_q;
  logic                 ov_d, ov_q;
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("vedic_multiplier_2x2: LATENCY must be 1 or 2");
  end
  if (LATENCY == 2) begin : g_in
    logic [VM2_IN_W-1:0] a_d, a_q, b_d, b_q;
    logic                v_d, v_q;
    // operands load only with in_valid so idle-bus garbage never reaches the core
    always_comb begin
      a_d = in_valid ? A : a_q;
      b_d = in_valid ? B : b_q;
      v_d = in_valid;
    end
    // input stage registers, cleared so in-flight operands are dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        v_q <= 1'b0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        v_q <= v_d;
      end
    end
    assign core_a = a_q;
    assign core_b = b_q;
    assign core_v = v_q;
  end else begin : g_no_in
    assign core_a = A;
    assign core_b = B;
    assign core_v = in_valid;
  end
  vedic_multiplier_2x2_half_adder u_ha_mid (
    .a     (core_a[1] & core_b[0]),
    .b     (core_a[0] & core_b[1]),
    .sum   (p1),
    .carry (c1)
  );
  vedic_multiplier_2x2_half_adder u_ha_top (
    .a     (core_a[1] & core_b[1]),
    .b     (c1),
    .sum   (p2),
    .carry (p3)
  );
  assign prod = {p3, p2, p1, core_a[0] & core_b[0]};
  // product updates only on a valid beat; otherwise P holds its last value
  always_comb begin
    p_d  = core_v ? prod : p_q;
    ov_d = core_v;
  end
  // output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      p_q  <= p_d;
      ov_q <= ov_d;
    end
  end
  assign P         = p_q;
  assign out_valid = ov_q;
endmodule

// File: tb/tb_vedic_multiplier_2x2.sv
// tb_vedic_multiplier_2x2: checks LATENCY=1 and LATENCY=2 instances against a delay-line product model
module tb_vedic_multiplier_2x2;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] A, B;
  logic       ov1, ov2;
  logic [3:0] p1, p2;
  int         tests = 0;
  int         fails = 0;
  bit         hv[$];
  int         hp[$];
  int         ep1, ep2;
  int         dir_a[7] = '{0, 1, 2, 3, 1, 2, 3};
  int         dir_b[7] = '{0, 1, 2, 3, 2, 1, 2};

  vedic_multiplier_2x2 #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .out_valid(ov1), .P(p1)
  );
  vedic_multiplier_2x2 #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .out_valid(ov2), .P(p2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hv = '{0, 0};
    hp = '{0, 0};
    ep1 = 0;
    ep2 = 0;
  endtask

  task automatic step(input string tag);
    bit v1, v2;
    @(posedge clk);
    if (rst_n) begin
      hv.push_back(in_valid);
      hp.push_back(int'(A) * int'(B));
    end else model_reset();
    v1 = hv[hv.size()-1];
    v2 = hv[hv.size()-2];
    if (v1) ep1 = hp[hp.size()-1];
    if (v2) ep2 = hp[hp.size()-2];
    #1;
    chk({tag, "_L1"}, {ov1, p1}, {v1, 4'(ep1)});
    chk({tag, "_L2"}, {ov2, p2}, {v2, 4'(ep2)});
  endtask

  task automatic drive(input bit v, input int a, input int b);
    in_valid = v;
    A = 2'(a);
    B = 2'(b);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1, 3, 3);
    repeat (3) step("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1, dir_a[i], dir_b[i]);
      step("directed");
    end
    drive(0, 0, 0);
    repeat (3) step("directed_flush");
    for (int i = 0; i < 16; i++) begin
      drive(1, i / 4, i % 4);
      step("exhaustive");
    end
    drive(1, 3, 2);
    step("gap_issue");
    drive(0, 1, 1);
    repeat (3) step("gap");
    drive(1, 2, 3);
    step("gap_resume");
    for (int i = 0; i < 60; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step("random");
    end
    drive(1, 2, 2);
    step("pre_async");
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear_L1", {ov1, p1}, 5'b0);
    chk("async_clear_L2", {ov2, p2}, 5'b0);
    model_reset();
    step("async_hold");
    rst_n = 1'b1;
    drive(1, 3, 3);
    step("midstream_issue");
    drive(0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midstream_clear_L2", {ov2, p2}, 5'b0);
    step("midstream_hold");
    rst_n = 1'b1;
    drive(1, 2, 1);
    step("after_release");
    drive(0, 0, 0);
    repeat (3) step("after_release_flush");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
